// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
// Shared constants and types for the deserializer slice.
//   DATA_W  : width of one signed serial word
//   NUM     : words per assembled frame
//   CNT_W   : width of the beat counter (0..NUM-1)
//   word_t  : one signed word, passed through bit-exact
//   cnt_t   : beat counter value
//   state_e : COLLECT (no frame pending) / HOLD (frame pending on output)
// -----------------------------------------------------------------------------
package deserializer_pkg;

    localparam int DATA_W = 32;
    localparam int NUM    = 16;
    localparam int CNT_W  = $clog2(NUM);

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]         cnt_t;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/deserializer_if.sv
// -----------------------------------------------------------------------------
// deserializer_if
// Word input stream plus frame output stream of the deserializer.
//   i_valid / i_ready / i_data : serial word handshake (producer -> block)
//   o_valid / o_ready / o_data : parallel frame handshake (block -> consumer)
// Modports:
//   slave  : the deserializer's view
//   master : the environment's view (producer and consumer side)
// -----------------------------------------------------------------------------
interface deserializer_if;
    import deserializer_pkg::*;

    logic  i_valid;
    logic  i_ready;
    word_t i_data;
    logic  o_valid;
    logic  o_ready;
    word_t o_data [NUM-1:0];

    modport slave (
        input  i_valid,
        input  i_data,
        input  o_ready,
        output i_ready,
        output o_valid,
        output o_data
    );

    modport master (
        output i_valid,
        output i_data,
        output o_ready,
        input  i_ready,
        input  o_valid,
        input  o_data
    );

endinterface

// File: rtl/deser_beat_cnt.sv
// -----------------------------------------------------------------------------
// deser_beat_cnt
// Mod-NUM beat counter. Counts accepted beats within a frame and flags the
// beat that completes it.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (cnt -> 0)
//   clr  : synchronous clear (cnt -> 0), lower priority than rst
//   inc  : an accepted beat this cycle
//   cnt  : index of the next word within the frame
//   last : inc && cnt == NUM-1 (combinational)
// -----------------------------------------------------------------------------
module deser_beat_cnt
    import deserializer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output cnt_t cnt,
    output logic last
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    assign last = inc && (cnt_q == cnt_t'(NUM - 1));
    assign cnt  = cnt_q;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = last ? '0 : cnt_q + cnt_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Assembles NUM signed words, accepted one per beat, into a parallel frame.
// The k-th accepted word of a frame lands in o_data[k]. Words 0..NUM-2 wait
// in a collect buffer; the last beat loads buffer + i_data into the output
// register in one step and raises o_valid on the next edge.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset; clears counter, o_valid, o_data and
//         the collect buffer; priority over clr
//   clr : synchronous clear; drops the partial frame and the pending output
//         (o_data keeps its value); a beat in the clr cycle is dropped
//   bus : deserializer_if.slave (word input stream, frame output stream)
//
// Configuration macro DESERIALIZER_DBUF_EN:
//   undefined : single buffer, i_ready = !o_valid, one bubble per frame
//   defined   : collection continues while a frame is pending; only the last
//               word of the next frame waits for the handoff, giving
//               1 word/cycle sustained throughput
// -----------------------------------------------------------------------------
module deserializer
    import deserializer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    deserializer_if.slave bus
);

    state_e state_q;
    state_e state_d;
    cnt_t   cnt;
    logic   cnt_last;
    logic   in_ready;
    logic   beat;
    logic   load_frame;
    logic   handoff;
    logic   o_valid;

    word_t  coll_q   [NUM-2:0];
    word_t  coll_d   [NUM-2:0];
    word_t  o_data_q [NUM-1:0];
    word_t  o_data_d [NUM-1:0];

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign beat    = bus.i_valid && in_ready;
    assign handoff = o_valid && bus.o_ready;

    // The counter's own clr/rst priority drops a beat arriving with clr; the
    // frame load must be suppressed the same way.
    assign load_frame = cnt_last && !clr;

    deser_beat_cnt u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (beat),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // -------------------------------------------------------------------------
    // Control FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // A last beat coinciding with a handoff keeps HOLD: the new frame
    // replaces the one being taken.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_COLLECT;
        end else if (load_frame) begin
            state_d = ST_HOLD;
        end else if (handoff) begin
            state_d = ST_COLLECT;
        end
    end

    always_comb begin
        o_valid = (state_q == ST_HOLD);
`ifdef DESERIALIZER_DBUF_EN
        // Only the completing word must wait until the pending frame leaves.
        in_ready = !(o_valid && !bus.o_ready && (cnt == cnt_t'(NUM - 1)));
`else
        in_ready = !o_valid;
`endif
    end

    assign bus.i_ready = in_ready;
    assign bus.o_valid = o_valid;
    assign bus.o_data  = o_data_q;

    // -------------------------------------------------------------------------
    // Collect buffer: words 0..NUM-2 of the frame being assembled
    // -------------------------------------------------------------------------
    always_comb begin
        coll_d = coll_q;
        if (beat && !clr && !cnt_last) begin
            for (int k = 0; k < NUM - 1; k++) begin
                if (cnt == cnt_t'(k)) begin
                    coll_d[k] = bus.i_data;
                end
            end
        end
    end

    // NOTE: the collect buffer and output register are flop arrays, not RAM,
    // so they take a reset and read as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM - 1; k++) begin
                coll_q[k] <= '0;
            end
        end else begin
            coll_q <= coll_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output register: loaded whole on the last beat, held until then
    // -------------------------------------------------------------------------
    always_comb begin
        o_data_d = o_data_q;
        if (load_frame) begin
            for (int k = 0; k < NUM - 1; k++) begin
                o_data_d[k] = coll_q[k];
            end
            o_data_d[NUM-1] = bus.i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM; k++) begin
                o_data_q[k] <= '0;
            end
        end else begin
            o_data_q <= o_data_d;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
// Self-checking bench for deserializer. A queue-based frame model predicts
// i_ready, o_valid and o_data every cycle; directed scenarios add literal
// expectations. Honours DESERIALIZER_DBUF_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_deserializer;
    import deserializer_pkg::*;

`ifdef DESERIALIZER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clr;

    deserializer_if bus ();

    deserializer dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    word_t part [$];
    word_t exp_data [NUM];
    bit    exp_valid = 1'b0;
    bit    chk_en    = 1'b0;
    bit    ov_en     = 1'b0;
    int    ov_cnt    = 0;
    int    stalls    = 0;
    int    idx;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (DBUF) begin
            return !(exp_valid && !bus.o_ready && part.size() == NUM - 1);
        end
        return !exp_valid;
    endfunction

    // Applies the edge to the model using the inputs present before it.
    task automatic model_update();
        bit rdy;
        if (rst) begin
            part.delete();
            exp_valid = 1'b0;
            foreach (exp_data[k]) exp_data[k] = '0;
        end else if (clr) begin
            part.delete();
            exp_valid = 1'b0;
        end else begin
            rdy = model_ready();
            if (exp_valid && bus.o_ready) exp_valid = 1'b0;
            if (bus.i_valid && rdy) begin
                part.push_back(bus.i_data);
                if (part.size() == NUM) begin
                    foreach (exp_data[k]) exp_data[k] = part[k];
                    part.delete();
                    exp_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Offers one word until accepted (bounded); leaves i_valid low.
    task automatic send_word(input word_t w);
        bit acc;
        bit done;
        done = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        for (int t = 0; t < 200 && !done; t++) begin
            acc = bus.i_ready;
            step();
            if (acc) done = 1'b1;
            else stalls++;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        bus.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        for (int t = 0; t < n; t++) step();
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("i_ready", {31'd0, bus.i_ready}, {31'd0, model_ready()});
            check("o_valid", {31'd0, bus.o_valid}, {31'd0, exp_valid});
            idx = 0;
            for (int k = NUM - 1; k >= 0; k--) begin
                if (bus.o_data[k] !== exp_data[k]) idx = k;
            end
            check($sformatf("o_data[%0d]", idx), bus.o_data[idx], exp_data[idx]);
        end
        if (ov_en && bus.o_valid) ov_cnt++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc_n;
        bit a;
        rst = 1'b1;
        clr = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;

        // Reset and idle
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
        check("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_o_data0", bus.o_data[0], 32'd0);
        check("rst_o_data15", bus.o_data[NUM-1], 32'd0);
        idle(20);
        check("idle_o_valid", {31'd0, bus.o_valid}, 32'd0);

        // Single frame 1..16
        bus.o_ready = 1'b1;
        for (int k = 0; k < NUM; k++) send_word(word_t'(k + 1));
        check("single_o_valid", {31'd0, bus.o_valid}, 32'd1);
        for (int k = 0; k < NUM; k++)
            check($sformatf("single_word%0d", k), bus.o_data[k], word_t'(k + 1));
        idle(1);
        check("single_o_valid_drop", {31'd0, bus.o_valid}, 32'd0);
        idle(2);

        // Output backpressure
        bus.o_ready = 1'b0;
        for (int k = 0; k < NUM; k++) send_word(word_t'(51 + k));
        acc_n = 0;
        for (int t = 0; t < 20; t++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = word_t'(201 + acc_n);
            a = bus.i_ready;
            step();
            if (a) acc_n++;
        end
        bus.i_valid = 1'b0;
        check("bp_accepted", acc_n, DBUF ? 32'd15 : 32'd0);
        check("bp_i_ready", {31'd0, bus.i_ready}, 32'd0);
        check("bp_o_valid", {31'd0, bus.o_valid}, 32'd1);
        check("bp_o_data0", bus.o_data[0], 32'd51);
        check("bp_o_data15", bus.o_data[NUM-1], 32'd66);
        bus.o_ready = 1'b1;
        for (int k = acc_n; k < NUM; k++) send_word(word_t'(201 + k));
        check("bp_next_word15", bus.o_data[NUM-1], 32'd216);
        idle(4);

        // Back-to-back 1..32
        stalls = 0;
        ov_cnt = 0;
        ov_en  = 1'b1;
        for (int k = 0; k < 2 * NUM; k++) send_word(word_t'(k + 1));
        check("b2b_last_word", bus.o_data[NUM-1], 32'd32);
        check("b2b_first_word", bus.o_data[0], 32'd17);
        idle(4);
        ov_en = 1'b0;
        check("b2b_stalls", stalls, DBUF ? 32'd0 : 32'd1);
        check("b2b_o_valid_cycles", ov_cnt, 32'd2);

        // clr mid-frame
        for (int k = 0; k < 7; k++) send_word(word_t'(100 + k));
        bus.i_valid = 1'b1;
        bus.i_data  = word_t'(107);
        clr = 1'b1;
        step();
        clr = 1'b0;
        bus.i_valid = 1'b0;
        for (int k = 0; k < NUM; k++) send_word(word_t'(-(k + 1)));
        check("clr_o_valid", {31'd0, bus.o_valid}, 32'd1);
        for (int k = 0; k < NUM; k++)
            check($sformatf("clr_word%0d", k), bus.o_data[k], word_t'(-(k + 1)));
        idle(3);

        // Extreme values
        for (int k = 0; k < NUM; k++)
            send_word((k % 2 == 0) ? word_t'(32'h8000_0000) : word_t'(32'h7FFF_FFFF));
        for (int k = 0; k < NUM; k++)
            check($sformatf("ext_word%0d", k), bus.o_data[k],
                  (k % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
        idle(3);

        // Randomized traffic with occasional clr and one reset
        for (int t = 0; t < 3000; t++) begin
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_data  = word_t'($urandom);
            bus.o_ready = ($urandom_range(0, 3) != 0);
            clr         = ($urandom_range(0, 63) == 0);
            rst         = (t == 1500);
            step();
        end
        rst = 1'b0;
        clr = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
